// File: rtl/ysyx_23060203_mem_arbiter_if.sv
// Bundle of every handshake and memory-bus signal around the IFU/LSU memory
// arbiter. The arbiter sits on the slave modport and the requesters plus the
// memory model sit on the master modport.
interface ysyx_23060203_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [2:0]  lsu_func;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_rdata;

  logic        mem_ren;
  logic [2:0]  mem_rfunc;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [2:0]  mem_wfunc;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_func, lsu_addr, lsu_wdata, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_ren, mem_rfunc, mem_raddr,
    output mem_wen, mem_wfunc, mem_waddr, mem_wdata
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_func, lsu_addr, lsu_wdata, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_ren, mem_rfunc, mem_raddr,
    input  mem_wen, mem_wfunc, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Shares one memory port between the instruction fetch unit and the
// load/store unit. One access is outstanding at a time: a request is accepted
// in IDLE, waits LAT cycles in BUSY (strobing memory on the last one) and its
// response is held in RESP until the owner takes it. Ties alternate, with
// the first tie after reset going to the IFU. LAT must lie in 1..15.
module ysyx_23060203_mem_arbiter #(
  parameter int         LAT      = 1,
  parameter logic [2:0] IFU_FUNC = 3'b010
) (
  input  logic                              clk,
  input  logic                              rstn,
  ysyx_23060203_mem_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        owner_lsu;
  logic        last_lsu;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func_q;
  logic        wen_q;
  logic [31:0] resp_q;

  logic        grant_lsu;
  logic        grant_ifu;
  logic        accept;
  logic        strobe;
  logic        in_busy;
  logic        in_resp;
  logic        resp_done;

  // Round-robin grant; ready is also masked by reset so nothing looks accepted while held in reset
  always_comb begin
    grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_lsu);
    grant_ifu = bus.ifu_req_valid & ~grant_lsu;
    bus.ifu_req_ready = rstn & (state == IDLE) & grant_ifu;
    bus.lsu_req_ready = rstn & (state == IDLE) & grant_lsu;
    accept    = bus.ifu_req_ready | bus.lsu_req_ready;
    in_busy   = (state == BUSY);
    in_resp   = (state == RESP);
    strobe    = in_busy & (cnt == 4'd0);
    resp_done = in_resp & (owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready);
  end

  // Memory strobes fire only on the last BUSY cycle; buses carry the latched request only while BUSY
  always_comb begin
    bus.mem_ren   = strobe & ~wen_q;
    bus.mem_wen   = strobe & wen_q;
    bus.mem_raddr = in_busy ? addr_q  : 32'd0;
    bus.mem_rfunc = in_busy ? func_q  : 3'd0;
    bus.mem_waddr = in_busy ? addr_q  : 32'd0;
    bus.mem_wfunc = in_busy ? func_q  : 3'd0;
    bus.mem_wdata = in_busy ? wdata_q : 32'd0;
  end

  // Only the owner of the pending response sees valid and data; the other side reads zero
  always_comb begin
    bus.ifu_resp_valid = in_resp & ~owner_lsu;
    bus.lsu_resp_valid = in_resp & owner_lsu;
    bus.ifu_rdata      = (in_resp & ~owner_lsu) ? resp_q : 32'd0;
    bus.lsu_rdata      = (in_resp & owner_lsu)  ? resp_q : 32'd0;
  end

  // Access sequencer: latch on accept, count down the latency, capture the result, wait for pickup
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b1;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      func_q    <= 3'd0;
      wen_q     <= 1'b0;
      resp_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner_lsu <= grant_lsu;
            last_lsu  <= grant_lsu;
            addr_q    <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            func_q    <= grant_lsu ? bus.lsu_func : IFU_FUNC;
            wen_q     <= grant_lsu & bus.lsu_wen;
            wdata_q   <= (grant_lsu & bus.lsu_wen) ? bus.lsu_wdata : 32'd0;
            cnt       <= 4'(LAT - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_q <= wen_q ? 32'd0 : bus.mem_rdata;
            state  <= RESP;
          end
        end
        RESP: begin
          if (resp_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: stimulus pushes the hand-computed
// expected access per requester, a negedge monitor pops it on the handshake
// and checks strobe timing, bus contents and the returned response.
module tb_ysyx_23060203_mem_arbiter;
  localparam int LAT = 3;

  logic clk;
  logic rstn;

  ysyx_23060203_mem_arbiter_if bus ();

  ysyx_23060203_mem_arbiter #(
    .LAT      (LAT),
    .IFU_FUNC (3'b010)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit          lsu;
    bit          store;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_ifu[$];
  exp_t exp_lsu[$];
  bit   exp_grant[$];

  int   n_vec;
  int   n_err;
  int   cyc;

  exp_t cur;
  bit   busy;
  bit   strobed;
  bit   resp_seen;
  bit   after_resp;
  int   acc;
  bit   hs_lsu;
  bit   g;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter referenced by the monitor
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational memory with a few known words
  always_comb begin
    case (bus.mem_raddr)
      32'h8000_0000: bus.mem_rdata = 32'h0000_0513;
      32'h8000_0008: bus.mem_rdata = 32'h1234_5678;
      32'h8000_0010: bus.mem_rdata = 32'hDEAD_BEEF;
      32'h8000_0014: bus.mem_rdata = 32'h00A0_0093;
      default:       bus.mem_rdata = 32'hCAFE_BABE;
    endcase
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the expected access on handshake and checks strobe and response
  always @(negedge clk) begin
    if (!rstn) begin
      check_output("reset_ctrl", {58'd0, bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid,
                                  bus.lsu_resp_valid, bus.mem_ren, bus.mem_wen}, 64'd0);
      check_output("reset_bus", {32'd0, bus.ifu_rdata | bus.lsu_rdata | bus.mem_raddr | bus.mem_waddr |
                                 bus.mem_wdata | {26'd0, bus.mem_rfunc, bus.mem_wfunc}}, 64'd0);
      busy       = 1'b0;
      after_resp = 1'b0;
    end else begin
      if (after_resp) begin
        if (bus.ifu_req_valid || bus.lsu_req_valid)
          check_output("idle_after_resp", {63'd0, bus.ifu_req_ready | bus.lsu_req_ready}, 64'd1);
        after_resp = 1'b0;
      end
      if (bus.ifu_req_valid && bus.lsu_req_valid)
        check_output("both_ready", {63'd0, bus.ifu_req_ready & bus.lsu_req_ready}, 64'd0);
      if (!busy)
        check_output("idle_mem_bus", {bus.mem_ren, bus.mem_wen, bus.mem_rfunc, bus.mem_wfunc,
                                      bus.mem_raddr | bus.mem_waddr | bus.mem_wdata}, 64'd0);
      if ((bus.ifu_req_valid && bus.ifu_req_ready) || (bus.lsu_req_valid && bus.lsu_req_ready)) begin
        hs_lsu = bus.lsu_req_ready;
        if (busy) check_output("overlap_accept", 64'd1, 64'd0);
        if (exp_grant.size() > 0) begin
          g = exp_grant.pop_front();
          check_output("grant_order", {63'd0, hs_lsu}, {63'd0, g});
        end
        if (hs_lsu ? (exp_lsu.size() == 0) : (exp_ifu.size() == 0)) begin
          check_output("unexpected_req", 64'd1, 64'd0);
        end else begin
          cur       = hs_lsu ? exp_lsu.pop_front() : exp_ifu.pop_front();
          busy      = 1'b1;
          strobed   = 1'b0;
          resp_seen = 1'b0;
          acc       = cyc + 1;
        end
      end
      if (bus.mem_ren || bus.mem_wen) begin
        if (!busy || strobed) begin
          check_output("spurious_strobe", {62'd0, bus.mem_ren, bus.mem_wen}, 64'd0);
        end else begin
          strobed = 1'b1;
          check_output("strobe_cycle", 64'(cyc), 64'(acc + LAT - 1));
          check_output("strobe_kind", {62'd0, bus.mem_ren, bus.mem_wen}, cur.store ? 64'd1 : 64'd2);
          if (cur.store) begin
            check_output("waddr", {32'd0, bus.mem_waddr}, {32'd0, cur.addr});
            check_output("wdata_wfunc", {29'd0, bus.mem_wfunc, bus.mem_wdata}, {29'd0, cur.func, cur.wdata});
          end else begin
            check_output("raddr", {32'd0, bus.mem_raddr}, {32'd0, cur.addr});
            check_output("rfunc", {61'd0, bus.mem_rfunc}, {61'd0, cur.func});
          end
        end
      end
      if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
        if (!busy || !strobed) begin
          check_output("spurious_resp", {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
        end else begin
          check_output("resp_owner",
                       {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid, cur.lsu ? bus.ifu_rdata : bus.lsu_rdata},
                       {30'd0, ~cur.lsu, cur.lsu, 32'd0});
          check_output("resp_data", {32'd0, cur.lsu ? bus.lsu_rdata : bus.ifu_rdata}, {32'd0, cur.rdata});
          check_output("ready_in_resp", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
          if (!resp_seen) check_output("resp_cycle", 64'(cyc), 64'(acc + LAT));
          resp_seen = 1'b1;
          if (cur.lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready) begin
            busy       = 1'b0;
            after_resp = 1'b1;
          end
        end
      end
    end
  end

  // Raise one request with its expected result and hold it until accepted
  task automatic apply_stimulus(input bit lsu, input bit store, input logic [2:0] func,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata);
    exp_t e;
    int   waited;
    bit   got;
    e.lsu = lsu; e.store = store; e.func = func; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    if (lsu) begin
      exp_lsu.push_back(e);
      bus.lsu_req_valid = 1'b1; bus.lsu_wen = store; bus.lsu_func = func;
      bus.lsu_addr = addr; bus.lsu_wdata = wdata;
    end else begin
      exp_ifu.push_back(e);
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = addr;
    end
    got = 1'b0;
    waited = 0;
    while (!got && waited < 100) begin
      @(negedge clk);
      got = lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
      waited++;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("[TB] FAIL req_timeout: addr %0h never accepted, required accept within 100 cycles", addr);
      if (lsu) void'(exp_lsu.pop_back()); else void'(exp_ifu.pop_back());
    end
    @(posedge clk);
    #1;
    if (lsu) begin
      bus.lsu_req_valid = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_func = 3'd0;
      bus.lsu_addr = 32'd0; bus.lsu_wdata = 32'd0;
    end else begin
      bus.ifu_req_valid = 1'b0; bus.ifu_addr = 32'd0;
    end
  endtask

  // Wait until the scoreboard has nothing outstanding
  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || exp_ifu.size() != 0 || exp_lsu.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    busy = 1'b0; after_resp = 1'b0;
    rstn = 1'b0;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = 32'd0; bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_func = 3'd0;
    bus.lsu_addr = 32'd0; bus.lsu_wdata = 32'd0; bus.lsu_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] LSU store");
    apply_stimulus(1'b1, 1'b1, 3'b000, 32'h8000_0004, 32'h0000_00A5, 32'h0);
    wait_drain();

    $display("[TB] IFU fetch");
    apply_stimulus(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0000_0513);
    wait_drain();

    $display("[TB] LSU LBU load");
    apply_stimulus(1'b1, 1'b0, 3'b100, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF);
    wait_drain();

    $display("[TB] response backpressure");
    bus.lsu_resp_ready = 1'b0;
    fork
      apply_stimulus(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678);
      begin
        for (int i = 0; i < 50 && !bus.lsu_resp_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 bus.lsu_resp_ready = 1'b1;
      end
      begin
        repeat (LAT + 2) @(posedge clk);
        #1 apply_stimulus(1'b0, 1'b0, 3'b010, 32'h8000_0014, 32'h0, 32'h00A0_0093);
      end
    join
    wait_drain();

    $display("[TB] reset during store, then tie arbitration");
    apply_stimulus(1'b1, 1'b1, 3'b010, 32'h8000_0030, 32'h0000_0077, 32'h0);
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    fork
      begin
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0000_0513);
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678);
      end
      begin
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 1'b1, 3'b001, 32'h8000_0040, 32'h0000_BEEF, 32'h0);
      end
    join
    wait_drain();

    repeat (3) @(negedge clk);
    check_output("queues_empty", 64'(exp_ifu.size() + exp_lsu.size() + exp_grant.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
